// File: rtl/ram_sp_cfg.sv
// Parametrised single-port synchronous RAM with a clear engine.
// After reset, and again on a clr pulse, the array is zeroed one word per
// cycle while busy is high. User accesses are accepted only in IDLE.
//
// Handshake: there is no backpressure. An access is taken when en=1, busy=0
// and clr=0 at a rising edge. Its result appears on dout with a one-cycle
// dout_valid strobe after the next edge (OUT_REG=0) or the one after that
// (OUT_REG=1). dout holds its last value whenever dout_valid is low.
module ram_sp_cfg #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int RW_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  ptr, ptr_next;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              in_range;
    logic              acc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic              req_load;
    logic [DATA_W-1:0] req_value;

    // First pipeline stage: result captured at the access edge.
    logic              req_valid;
    logic [DATA_W-1:0] req_data;
    // Second stage: the latency-1 output.
    logic              out1_valid;
    logic [DATA_W-1:0] out1_data;

    assign idx      = addr[IDX_W-1:0];
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign acc      = (state == ST_IDLE) && en && !clr;
    assign old_word = in_range ? mem[idx] : '0;
    assign busy     = (state == ST_CLEAR);

    // Clear-engine state and pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next state: sweep the pointer across the array, restart on clr.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            ST_CLEAR: begin
                if (clr) begin
                    ptr_next = '0;
                end else if (ptr == LAST_IDX) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            default: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
        endcase
    end

    // Array write port: clear engine has priority; out-of-range writes drop.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else if (acc && wr && in_range) begin
            mem[idx] <= din;
        end
    end

    // Decide what an accepted access returns, honouring the read-during-write mode.
    always_comb begin
        req_load  = 1'b0;
        req_value = '0;
        if (acc) begin
            if (!wr) begin
                req_load  = 1'b1;
                req_value = old_word;
            end else if (RW_MODE == 0) begin
                req_load  = 1'b1;
                req_value = old_word;
            end else if (RW_MODE == 1) begin
                req_load  = 1'b1;
                req_value = in_range ? din : '0;
            end
        end
    end

    // Two-stage result pipeline; data registers only move with a valid result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_valid  <= 1'b0;
            req_data   <= '0;
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else begin
            req_valid  <= req_load;
            if (req_load) req_data <= req_value;
            out1_valid <= req_valid;
            if (req_valid) out1_data <= req_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              out2_valid;
            logic [DATA_W-1:0] out2_data;

            // Extra output register for the latency-2 configuration.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out2_valid <= 1'b0;
                    out2_data  <= '0;
                end else begin
                    out2_valid <= out1_valid;
                    if (out1_valid) out2_data <= out1_data;
                end
            end

            assign dout       = out2_data;
            assign dout_valid = out2_valid;
        end else begin : g_no_out_reg
            assign dout       = out1_data;
            assign dout_valid = out1_valid;
        end
    endgenerate

endmodule
